// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a multiplexed 7-segment display bus.
// Waits for the bus to be stable, decodes the lit digit back to BCD, flags bad
// patterns, and strobes once per complete 4-digit scan.
module seven_seg_capture #(
    parameter int unsigned CC            = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seven_seg,
    input  logic [3:0]  digit_en,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_stb,
    output logic        seg_error
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

    logic [6:0]    seg_n;
    logic [3:0]    en_n;
    logic [6:0]    s_seg;
    logic [3:0]    s_en;
    logic [CW-1:0] cnt;
    logic [3:0]    seen;
    logic          onehot;
    logic          stable;
    logic          capture;
    logic [3:0]    dec_val;
    logic          dec_ok;
    logic          unused_dp;

    // Decimal point / bit 7 carries no digit information.
    assign unused_dp = seven_seg[7];

    // Fold both bus polarities into active-low segments, active-high enables.
    always_comb begin
        if (CC != 0) begin
            seg_n = ~seven_seg[6:0];
            en_n  = ~digit_en;
        end else begin
            seg_n = seven_seg[6:0];
            en_n  = digit_en;
        end
    end

    // Bus is stable when it matches last cycle and exactly one digit is enabled.
    always_comb begin
        onehot  = (en_n != 4'b0000) && ((en_n & (en_n - 4'd1)) == 4'b0000);
        stable  = (seg_n == s_seg) && (en_n == s_en) && onehot;
        capture = stable && (cnt == CW'(SETTLE_CYCLES - 1));
    end

    // Segment pattern (active-low, a..g) to BCD value.
    always_comb begin
        dec_val = 4'd0;
        dec_ok  = 1'b1;
        case (s_seg)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // Input sampling, settle counter, capture into slot, error and frame tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg       <= 7'd0;
            s_en        <= 4'd0;
            cnt         <= '0;
            seen        <= 4'd0;
            digits      <= 16'd0;
            digit_valid <= 4'd0;
            frame_stb   <= 1'b0;
            seg_error   <= 1'b0;
        end else begin
            s_seg     <= seg_n;
            s_en      <= en_n;
            frame_stb <= 1'b0;

            // Saturation stops a long dwell from being captured more than once.
            if (stable) begin
                if (cnt != CW'(SETTLE_CYCLES)) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end

            if (err_clr) begin
                seg_error <= 1'b0;
            end

            if (capture) begin
                if (dec_ok) begin
                    for (int i = 0; i < 4; i++) begin
                        if (s_en[i]) begin
                            digits[4*i +: 4] <= dec_val;
                        end
                    end
                    digit_valid <= digit_valid | s_en;
                    if ((seen | s_en) == 4'b1111) begin
                        frame_stb <= 1'b1;
                        seen      <= 4'd0;
                    end else begin
                        seen <= seen | s_en;
                    end
                end else begin
                    digit_valid <= digit_valid & ~s_en;
                    // Placed after the clear so a coincident new error wins.
                    seg_error   <= 1'b1;
                end
            end
        end
    end

endmodule
